// File: rtl/adau_pkg.sv
// Shared ADAU1761 serial-audio definitions: default widths, receiver FSM states
// and the stereo pair payload used by the I2S receive and transmit paths.
package adau_pkg;

    localparam int unsigned ADAU_SAMPLE_WIDTH = 24;
    localparam int unsigned ADAU_SLOT_WIDTH   = 32;
    localparam int unsigned ADAU_FIFO_DEPTH   = 4;

    typedef enum logic [1:0] {
        WAIT_FRAME = 2'd0,
        RX_LEFT    = 2'd1,
        RX_RIGHT   = 2'd2
    } i2s_rx_state_t;

    typedef struct packed {
        logic [ADAU_SAMPLE_WIDTH-1:0] left;
        logic [ADAU_SAMPLE_WIDTH-1:0] right;
    } adau_pair_t;

endpackage

// File: rtl/adau_sample_fifo.sv
// Synchronous show-ahead FIFO for stereo pairs; head word and valid flag are
// registered so the consumer sees no combinational path from its pop request.
module adau_sample_fifo #(
    parameter int unsigned WIDTH = 48,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic             o_full_c
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic             w_do_push;
    logic             w_do_pop;
    logic             w_head_new;
    logic [PTR_W-1:0] w_rd_ptr_nxt;
    logic [CNT_W-1:0] w_count_nxt;

    assign o_full_c     = (r_count == CNT_W'(DEPTH));
    assign w_do_pop     = i_pop && (r_count != '0);
    assign w_do_push    = i_push && (!o_full_c || w_do_pop);
    assign w_rd_ptr_nxt = r_rd_ptr + PTR_W'(w_do_pop);
    assign w_count_nxt  = r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    // The incoming word becomes the head when nothing older remains after the pop.
    assign w_head_new   = w_do_push && ((r_count - CNT_W'(w_do_pop)) == '0);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            o_data   <= '0;
            o_valid  <= 1'b0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(w_do_push);
            r_rd_ptr <= w_rd_ptr_nxt;
            r_count  <= w_count_nxt;
            o_valid  <= (w_count_nxt != '0);
            o_data   <= w_head_new ? i_data : r_mem[w_rd_ptr_nxt];
        end
    end

endmodule

// File: rtl/adau_i2s_rx.sv
// ADAU1761 ADC-path I2S receiver: oversamples bclk/lrclk/sdata in sys_clk and
// delivers left/right pairs on valid/ready. ADAU_I2S_RX_FIFO_EN selects a FIFO over a single holding register.
module adau_i2s_rx
    import adau_pkg::*;
#(
    parameter int unsigned SAMPLE_WIDTH = ADAU_SAMPLE_WIDTH,
    parameter int unsigned SLOT_WIDTH   = ADAU_SLOT_WIDTH,
    parameter int unsigned FIFO_DEPTH   = ADAU_FIFO_DEPTH
) (
    input  logic                    sys_clk,
    input  logic                    reset_n,
    input  logic                    ac_bclk,
    input  logic                    ac_lrclk,
    input  logic                    ac_adc_sdata,
    output logic [SAMPLE_WIDTH-1:0] sample_left,
    output logic [SAMPLE_WIDTH-1:0] sample_right,
    output logic                    sample_valid,
    input  logic                    sample_ready,
    output logic                    overrun,
    output logic                    frame_err
);

    localparam int unsigned CNT_W  = $clog2(SAMPLE_WIDTH + 1);
    localparam int unsigned PAIR_W = 2 * SAMPLE_WIDTH;

    if (SLOT_WIDTH < SAMPLE_WIDTH + 1) begin : g_bad_slot
        $error("SLOT_WIDTH must be at least SAMPLE_WIDTH+1");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two, at least 2");
    end

    logic r_bclk_s1, r_bclk_s2, r_bclk_d;
    logic r_lr_s1, r_lr_s2;
    logic r_sd_s1, r_sd_s2;

    logic                    r_lr_prev;
    logic [CNT_W-1:0]        r_bit_cnt;
    logic [SAMPLE_WIDTH-1:0] r_shift;
    logic [SAMPLE_WIDTH-1:0] r_left_hold;
    logic                    r_left_ok;
    i2s_rx_state_t           r_state;
    i2s_rx_state_t           w_state_nxt;

    logic              w_bit_stb;
    logic              w_lr_chg;
    logic              w_cnt_full;
    logic              w_push;
    logic              w_ferr;
    logic              w_left_latch;
    logic              w_left_bad;
    logic              w_pop;
    logic              w_drop;
    logic [PAIR_W-1:0] w_pair;
    logic [PAIR_W-1:0] w_head;
    logic              w_head_valid;

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bclk_s1 <= 1'b0;
            r_bclk_s2 <= 1'b0;
            r_bclk_d  <= 1'b0;
            r_lr_s1   <= 1'b0;
            r_lr_s2   <= 1'b0;
            r_sd_s1   <= 1'b0;
            r_sd_s2   <= 1'b0;
        end else begin
            r_bclk_s1 <= ac_bclk;
            r_bclk_s2 <= r_bclk_s1;
            r_bclk_d  <= r_bclk_s2;
            r_lr_s1   <= ac_lrclk;
            r_lr_s2   <= r_lr_s1;
            r_sd_s1   <= ac_adc_sdata;
            r_sd_s2   <= r_sd_s1;
        end
    end

    assign w_bit_stb  = r_bclk_s2 && !r_bclk_d;
    assign w_lr_chg   = w_bit_stb && (r_lr_s2 != r_lr_prev);
    assign w_cnt_full = (r_bit_cnt == CNT_W'(SAMPLE_WIDTH));
    assign w_pair     = {r_left_hold, r_shift};

    // Word-select edge is the I2S delay bit: it restarts the count and carries no data.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lr_prev   <= 1'b1;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_left_hold <= '0;
            r_left_ok   <= 1'b0;
        end else if (w_bit_stb) begin
            if (w_lr_chg) begin
                r_lr_prev <= r_lr_s2;
                r_bit_cnt <= '0;
                r_shift   <= '0;
            end else if (r_bit_cnt < CNT_W'(SAMPLE_WIDTH)) begin
                r_shift   <= {r_shift[SAMPLE_WIDTH-2:0], r_sd_s2};
                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end
            if (w_left_latch) begin
                r_left_hold <= r_shift;
                r_left_ok   <= 1'b1;
            end else if (w_left_bad) begin
                r_left_ok   <= 1'b0;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= WAIT_FRAME;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_push       = 1'b0;
        w_ferr       = 1'b0;
        w_left_latch = 1'b0;
        w_left_bad   = 1'b0;
        if (w_lr_chg) begin
            case (r_state)
                WAIT_FRAME: begin
                    if (!r_lr_s2) begin
                        w_state_nxt = RX_LEFT;
                    end
                end
                RX_LEFT: begin
                    if (r_lr_s2) begin
                        w_state_nxt = RX_RIGHT;
                        if (w_cnt_full) begin
                            w_left_latch = 1'b1;
                        end else begin
                            w_ferr     = 1'b1;
                            w_left_bad = 1'b1;
                        end
                    end
                end
                RX_RIGHT: begin
                    if (!r_lr_s2) begin
                        w_state_nxt = RX_LEFT;
                        if (w_cnt_full) begin
                            w_push = r_left_ok;
                        end else begin
                            w_ferr = 1'b1;
                        end
                    end
                end
                default: w_state_nxt = WAIT_FRAME;
            endcase
        end
    end

    assign w_pop = w_head_valid && sample_ready;

`ifdef ADAU_I2S_RX_FIFO_EN
    logic w_fifo_full;

    adau_sample_fifo #(
        .WIDTH (PAIR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (sys_clk),
        .rst_n    (reset_n),
        .i_push   (w_push),
        .i_data   (w_pair),
        .i_pop    (w_pop),
        .o_data   (w_head),
        .o_valid  (w_head_valid),
        .o_full_c (w_fifo_full)
    );

    assign w_drop = w_push && w_fifo_full && !w_pop;
`else
    logic [PAIR_W-1:0] r_hold;
    logic              r_hold_valid;

    assign w_drop = w_push && r_hold_valid && !w_pop;

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
        end else if (w_push && !w_drop) begin
            r_hold       <= w_pair;
            r_hold_valid <= 1'b1;
        end else if (w_pop) begin
            r_hold_valid <= 1'b0;
        end
    end

    assign w_head       = r_hold;
    assign w_head_valid = r_hold_valid;
`endif

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            overrun   <= w_drop;
            frame_err <= w_ferr;
        end
    end

    assign sample_left  = w_head[PAIR_W-1:SAMPLE_WIDTH];
    assign sample_right = w_head[SAMPLE_WIDTH-1:0];
    assign sample_valid = w_head_valid;

endmodule

// File: tb/tb_adau_i2s_rx.sv
// Directed bench for adau_i2s_rx: I2S frames driven at 10 sys_clk per bclk,
// pairs/pulses collected on the falling sys_clk edge and compared to hand values.
module tb_adau_i2s_rx;
    import adau_pkg::*;

`ifdef ADAU_I2S_RX_FIFO_EN
    localparam int CAP = 4;
`else
    localparam int CAP = 1;
`endif

    logic        sys_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ac_bclk = 1'b0;
    logic        ac_lrclk = 1'b1;
    logic        ac_adc_sdata = 1'b0;
    logic        sample_ready = 1'b0;
    logic [23:0] sample_left;
    logic [23:0] sample_right;
    logic        sample_valid;
    logic        overrun;
    logic        frame_err;

    int n_checks = 0;
    int n_fail   = 0;
    int n_ovr    = 0;
    int n_ferr   = 0;
    adau_pair_t got_q[$];

    always #5 sys_clk = ~sys_clk;

    adau_i2s_rx #(
        .SAMPLE_WIDTH (24),
        .SLOT_WIDTH   (32),
        .FIFO_DEPTH   (4)
    ) dut (
        .sys_clk      (sys_clk),
        .reset_n      (reset_n),
        .ac_bclk      (ac_bclk),
        .ac_lrclk     (ac_lrclk),
        .ac_adc_sdata (ac_adc_sdata),
        .sample_left  (sample_left),
        .sample_right (sample_right),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .overrun      (overrun),
        .frame_err    (frame_err)
    );

    always @(negedge sys_clk) begin
        if (sample_valid && sample_ready) got_q.push_back({sample_left, sample_right});
        if (overrun)   n_ovr++;
        if (frame_err) n_ferr++;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic lr, input logic sd);
        @(negedge sys_clk);
        ac_bclk = 1'b0; ac_lrclk = lr; ac_adc_sdata = sd;
        repeat (5) @(negedge sys_clk);
        ac_bclk = 1'b1;
        repeat (4) @(negedge sys_clk);
    endtask

    // Slot = delay bit, up to 24 data bits MSB first, then ones to fill.
    task automatic send_slot(input logic lr, input logic [23:0] data, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            if (i >= 1 && i <= 24) send_bit(lr, data[24 - i]);
            else                   send_bit(lr, 1'b1);
        end
    endtask

    task automatic send_frame(input logic [23:0] l, input logic [23:0] r);
        send_slot(1'b0, l, 32);
        send_slot(1'b1, r, 32);
    endtask

    task automatic close_frame();
        send_bit(1'b0, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge sys_clk);
        reset_n = 1'b0; ac_bclk = 1'b0; ac_lrclk = 1'b1; ac_adc_sdata = 1'b0;
        repeat (4) @(negedge sys_clk);
        reset_n = 1'b1;
        repeat (4) @(negedge sys_clk);
    endtask

    task automatic set_ready(input logic v);
        @(posedge sys_clk);
        #1 sample_ready = v;
    endtask

    task automatic wait_pairs(input int target);
        for (int k = 0; k < 300 && got_q.size() < target; k++) @(negedge sys_clk);
        repeat (10) @(negedge sys_clk);
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int ovr0;
        int ferr0;

        // Reset values
        repeat (3) @(negedge sys_clk);
        check_eq("rst_valid", 64'(sample_valid), 64'd0);
        check_eq("rst_left", 64'(sample_left), 64'd0);
        check_eq("rst_right", 64'(sample_right), 64'd0);
        check_eq("rst_overrun", 64'(overrun), 64'd0);
        check_eq("rst_frame_err", 64'(frame_err), 64'd0);
        reset_n = 1'b1;
        repeat (4) @(negedge sys_clk);

        // Basic capture, consumer always ready
        set_ready(1'b1);
        base = got_q.size(); ferr0 = n_ferr; ovr0 = n_ovr;
        for (int f = 0; f < 3; f++) send_frame(24'h123456, 24'hABCDEF);
        close_frame();
        wait_pairs(base + 3);
        check_eq("basic_count", 64'(got_q.size() - base), 64'd3);
        for (int i = 0; i < 3; i++) begin
            if (got_q.size() > base + i)
                check_eq("basic_pair", 64'(got_q[base + i]), 64'h123456ABCDEF);
        end
        check_eq("basic_ferr", 64'(n_ferr - ferr0), 64'd0);
        check_eq("basic_ovr", 64'(n_ovr - ovr0), 64'd0);

        // Startup alignment: reset released in the middle of a right slot
        @(negedge sys_clk);
        reset_n = 1'b0; ac_bclk = 1'b0; ac_lrclk = 1'b1;
        for (int i = 0; i < 5; i++) send_bit(1'b1, i[0]);
        reset_n = 1'b1;
        base = got_q.size(); ferr0 = n_ferr;
        for (int i = 0; i < 10; i++) send_bit(1'b1, i[0]);
        send_frame(24'h111111, 24'h222222);
        repeat (20) @(negedge sys_clk);
        check_eq("align_none_yet", 64'(got_q.size() - base), 64'd0);
        close_frame();
        wait_pairs(base + 1);
        check_eq("align_count", 64'(got_q.size() - base), 64'd1);
        if (got_q.size() > base) check_eq("align_pair", 64'(got_q[base]), 64'h111111222222);
        check_eq("align_ferr", 64'(n_ferr - ferr0), 64'd0);

        // Backpressure: six frames with the consumer stalled
        do_reset();
        set_ready(1'b0);
        base = got_q.size(); ovr0 = n_ovr;
        for (int f = 1; f <= 6; f++) send_frame(24'(f), 24'(f + 256));
        close_frame();
        repeat (20) @(negedge sys_clk);
        check_eq("bp_overruns", 64'(n_ovr - ovr0), 64'(6 - CAP));
        check_eq("bp_valid", 64'(sample_valid), 64'd1);
        check_eq("bp_head_left", 64'(sample_left), 64'h1);
        check_eq("bp_head_right", 64'(sample_right), 64'h101);
        set_ready(1'b1);
        wait_pairs(base + CAP);
        check_eq("bp_drain_count", 64'(got_q.size() - base), 64'(CAP));
        for (int i = 0; i < CAP; i++) begin
            if (got_q.size() > base + i)
                check_eq("bp_drain_pair", 64'(got_q[base + i]), {16'h0, 24'(i + 1), 24'(i + 257)});
        end
        check_eq("bp_empty", 64'(sample_valid), 64'd0);

        // Short left slot, then short right slot
        do_reset();
        base = got_q.size(); ferr0 = n_ferr;
        send_frame(24'h0F0F0F, 24'hF0F0F0);
        send_slot(1'b0, 24'h0ABCDE, 21);
        send_slot(1'b1, 24'h135790, 32);
        send_slot(1'b0, 24'h111111, 32);
        send_slot(1'b1, 24'h222222, 21);
        send_frame(24'h2468AC, 24'h0FEDCB);
        close_frame();
        wait_pairs(base + 2);
        check_eq("short_ferr", 64'(n_ferr - ferr0), 64'd2);
        check_eq("short_count", 64'(got_q.size() - base), 64'd2);
        if (got_q.size() > base + 1) begin
            check_eq("short_first", 64'(got_q[base]), 64'h0F0F0FF0F0F0);
            check_eq("short_next", 64'(got_q[base + 1]), 64'h2468AC0FEDCB);
        end

        // Reset during a right slot with pairs queued
        do_reset();
        set_ready(1'b0);
        send_frame(24'hAAAAAA, 24'h555555);
        send_frame(24'hBBBBBB, 24'h444444);
        send_slot(1'b0, 24'hCCCCCC, 32);
        for (int i = 0; i < 10; i++) send_bit(1'b1, 1'b1);
        check_eq("mid_prefill_valid", 64'(sample_valid), 64'd1);
        @(negedge sys_clk);
        #2 reset_n = 1'b0;
        #1 check_eq("mid_valid_now", 64'(sample_valid), 64'd0);
        ac_bclk = 1'b0; ac_lrclk = 1'b1;
        repeat (4) @(negedge sys_clk);
        reset_n = 1'b1;
        base = got_q.size();
        set_ready(1'b1);
        repeat (30) @(negedge sys_clk);
        check_eq("mid_empty", 64'(got_q.size() - base), 64'd0);
        send_frame(24'h0000C3, 24'h3C0000);
        close_frame();
        wait_pairs(base + 1);
        check_eq("mid_count", 64'(got_q.size() - base), 64'd1);
        if (got_q.size() > base) check_eq("mid_pair", 64'(got_q[base]), 64'h0000C33C0000);

        // Boundary values pushed into a full store in the same cycle as a pop
        do_reset();
        set_ready(1'b0);
        base = got_q.size(); ovr0 = n_ovr;
        for (int f = 1; f <= CAP; f++) send_frame(24'(f + 16), 24'(f + 32));
        send_frame(24'h800000, 24'h7FFFFF);
        @(negedge sys_clk);
        ac_bclk = 1'b0; ac_lrclk = 1'b0; ac_adc_sdata = 1'b1;
        repeat (5) @(negedge sys_clk);
        ac_bclk = 1'b1;
        @(posedge sys_clk);
        @(posedge sys_clk);
        #1 sample_ready = 1'b1;
        @(posedge sys_clk);
        #1 sample_ready = 1'b0;
        repeat (20) @(negedge sys_clk);
        check_eq("bnd_overrun", 64'(n_ovr - ovr0), 64'd0);
        set_ready(1'b1);
        wait_pairs(base + CAP + 1);
        check_eq("bnd_count", 64'(got_q.size() - base), 64'(CAP + 1));
        if (got_q.size() > base) check_eq("bnd_first", 64'(got_q[base]), 64'h000011000021);
        if (got_q.size() == base + CAP + 1)
            check_eq("bnd_pair", 64'(got_q[base + CAP]), 64'h8000007FFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
